// File: rtl/fft_job_sched.sv
// fft_job_sched: shares one fft accelerator between two AXI-Stream requesters.
//
// Requesters s00/s01 are arbitrated round-robin. The granted requester streams
// SIZE operand beats into the accelerator (acc_axis). acc_start then pulses for
// one cycle. The accelerator result frame (acc_res) is then passed to m00_axis.
// m00_axis_tid carries the owning requester.
//
// Ports
//   s00_axi_aclk / s00_axi_aresetn   clock, synchronous active-low reset
//   s00_axis_*, s01_axis_*           requester operand streams (in)
//   acc_axis_*                       operand stream to fft core (out)
//   acc_start                        one-cycle start pulse to fft core
//   acc_res_*                        result stream from fft core (in)
//   m00_axis_*, m00_axis_tid         tagged result stream (out)
//   busy, len_err, err, job_count    status
//
// Optional feature: define FFT_SCHED_WDT_EN to enable the DRAIN watchdog.
// The watchdog aborts a job after TIMEOUT_CYCLES cycles without a result beat
// and sets err. Without the macro, err is tied low and DRAIN waits forever.
//
// state | meaning
// IDLE  | no job; arbitrate requesters, register grant
// LOAD  | stream SIZE beats from granted requester into accelerator
// START | acc_start high for this single cycle
// DRAIN | forward result frame to m00 until tlast is accepted
module fft_job_sched #(
  parameter int SIZE           = 2,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  s00_axi_aclk,
  input  logic                  s00_axi_aresetn,
  input  logic [DATA_WIDTH-1:0] s00_axis_tdata,
  input  logic                  s00_axis_tvalid,
  input  logic                  s00_axis_tlast,
  output logic                  s00_axis_tready,
  input  logic [DATA_WIDTH-1:0] s01_axis_tdata,
  input  logic                  s01_axis_tvalid,
  input  logic                  s01_axis_tlast,
  output logic                  s01_axis_tready,
  output logic [DATA_WIDTH-1:0] acc_axis_tdata,
  output logic                  acc_axis_tvalid,
  output logic                  acc_axis_tlast,
  input  logic                  acc_axis_tready,
  output logic                  acc_start,
  input  logic [DATA_WIDTH-1:0] acc_res_tdata,
  input  logic                  acc_res_tvalid,
  input  logic                  acc_res_tlast,
  output logic                  acc_res_tready,
  output logic [DATA_WIDTH-1:0] m00_axis_tdata,
  output logic                  m00_axis_tvalid,
  output logic                  m00_axis_tlast,
  input  logic                  m00_axis_tready,
  output logic                  m00_axis_tid,
  output logic                  busy,
  output logic                  len_err,
  output logic                  err,
  output logic [15:0]           job_count
);

  localparam int CNT_W = (SIZE > 1) ? $clog2(SIZE) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(SIZE - 1);

  typedef enum logic [1:0] {IDLE, LOAD, START, DRAIN} state_t;

  state_t           state, state_nxt;
  logic             grant, grant_nxt;
  logic             last_grant, last_grant_nxt;
  logic [CNT_W-1:0] word_cnt, word_cnt_nxt;
  logic [15:0]      job_count_nxt;
  logic             len_err_nxt;
  logic             acc_start_nxt;

  logic [DATA_WIDTH-1:0] req_tdata;
  logic                  req_tvalid;
  logic                  req_tlast;
  logic                  load_fire;
  logic                  res_fire;
  logic                  wdt_expired;

  assign req_tdata  = grant ? s01_axis_tdata  : s00_axis_tdata;
  assign req_tvalid = grant ? s01_axis_tvalid : s00_axis_tvalid;
  assign req_tlast  = grant ? s01_axis_tlast  : s00_axis_tlast;

  assign load_fire = (state == LOAD)  && req_tvalid && acc_axis_tready;
  assign res_fire  = (state == DRAIN) && acc_res_tvalid && m00_axis_tready;

  assign busy         = (state != IDLE);
  assign m00_axis_tid = grant;

  // Stream muxing: handshakes are only opened in the phase that owns them, so
  // early accelerator results and ungranted requesters are held off.
  always_comb begin
    s00_axis_tready = 1'b0;
    s01_axis_tready = 1'b0;
    acc_axis_tdata  = req_tdata;
    acc_axis_tvalid = 1'b0;
    acc_axis_tlast  = 1'b0;
    acc_res_tready  = 1'b0;
    m00_axis_tdata  = acc_res_tdata;
    m00_axis_tvalid = 1'b0;
    m00_axis_tlast  = 1'b0;
    if (state == LOAD) begin
      s00_axis_tready = !grant && acc_axis_tready;
      s01_axis_tready =  grant && acc_axis_tready;
      acc_axis_tvalid = req_tvalid;
      // tlast is regenerated from the beat count; upstream tlast is only checked
      acc_axis_tlast  = (word_cnt == LAST_BEAT);
    end
    if (state == DRAIN) begin
      acc_res_tready  = m00_axis_tready;
      m00_axis_tvalid = acc_res_tvalid;
      m00_axis_tlast  = acc_res_tlast;
    end
  end

  always_comb begin
    state_nxt      = state;
    grant_nxt      = grant;
    last_grant_nxt = last_grant;
    word_cnt_nxt   = word_cnt;
    job_count_nxt  = job_count;
    len_err_nxt    = len_err;
    acc_start_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (s00_axis_tvalid || s01_axis_tvalid) begin
          grant_nxt = (s00_axis_tvalid && s01_axis_tvalid) ? !last_grant : s01_axis_tvalid;
          state_nxt = LOAD;
        end
      end
      LOAD: begin
        if (load_fire) begin
          if (req_tlast != (word_cnt == LAST_BEAT)) len_err_nxt = 1'b1;
          if (word_cnt == LAST_BEAT) begin
            word_cnt_nxt  = '0;
            acc_start_nxt = 1'b1;
            state_nxt     = START;
          end else begin
            word_cnt_nxt = word_cnt + 1'b1;
          end
        end
      end
      START: state_nxt = DRAIN;
      DRAIN: begin
        if (res_fire && acc_res_tlast) begin
          state_nxt      = IDLE;
          last_grant_nxt = grant;
          job_count_nxt  = job_count + 16'd1;
        end else if (wdt_expired) begin
          state_nxt      = IDLE;
          last_grant_nxt = grant;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge s00_axi_aclk) begin
    if (!s00_axi_aresetn) begin
      state      <= IDLE;
      grant      <= 1'b0;
      last_grant <= 1'b1;
      word_cnt   <= '0;
      job_count  <= '0;
      len_err    <= 1'b0;
      acc_start  <= 1'b0;
    end else begin
      state      <= state_nxt;
      grant      <= grant_nxt;
      last_grant <= last_grant_nxt;
      word_cnt   <= word_cnt_nxt;
      job_count  <= job_count_nxt;
      len_err    <= len_err_nxt;
      acc_start  <= acc_start_nxt;
    end
  end

`ifdef FFT_SCHED_WDT_EN
  logic [15:0] wdt_cnt;
  logic        err_q;

  // An accepted beat restarts the count, so it never expires on a live stream.
  assign wdt_expired = (state == DRAIN) && !res_fire &&
                       (wdt_cnt == 16'(TIMEOUT_CYCLES - 1));
  assign err = err_q;

  always_ff @(posedge s00_axi_aclk) begin
    if (!s00_axi_aresetn) begin
      wdt_cnt <= '0;
      err_q   <= 1'b0;
    end else begin
      if (state == START || res_fire) wdt_cnt <= '0;
      else if (state == DRAIN)        wdt_cnt <= wdt_cnt + 16'd1;
      if (wdt_expired) err_q <= 1'b1;
    end
  end
`else
  assign wdt_expired = 1'b0;
  assign err         = 1'b0;
`endif

endmodule

// File: tb/tb_fft_job_sched.sv
module tb_fft_job_sched;
  localparam int SIZE = 2;
  localparam int DW   = 32;
  localparam int TMO  = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          aresetn;
  logic [DW-1:0] s00_axis_tdata, s01_axis_tdata, acc_axis_tdata, acc_res_tdata, m00_axis_tdata;
  logic s00_axis_tvalid, s00_axis_tlast, s00_axis_tready;
  logic s01_axis_tvalid, s01_axis_tlast, s01_axis_tready;
  logic acc_axis_tvalid, acc_axis_tlast, acc_axis_tready, acc_start;
  logic acc_res_tvalid, acc_res_tlast, acc_res_tready;
  logic m00_axis_tvalid, m00_axis_tlast, m00_axis_tready, m00_axis_tid;
  logic busy, len_err, err;
  logic [15:0] job_count;

  fft_job_sched #(.SIZE(SIZE), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TMO)) dut (
    .s00_axi_aclk(clk), .s00_axi_aresetn(aresetn),
    .s00_axis_tdata(s00_axis_tdata), .s00_axis_tvalid(s00_axis_tvalid),
    .s00_axis_tlast(s00_axis_tlast), .s00_axis_tready(s00_axis_tready),
    .s01_axis_tdata(s01_axis_tdata), .s01_axis_tvalid(s01_axis_tvalid),
    .s01_axis_tlast(s01_axis_tlast), .s01_axis_tready(s01_axis_tready),
    .acc_axis_tdata(acc_axis_tdata), .acc_axis_tvalid(acc_axis_tvalid),
    .acc_axis_tlast(acc_axis_tlast), .acc_axis_tready(acc_axis_tready),
    .acc_start(acc_start),
    .acc_res_tdata(acc_res_tdata), .acc_res_tvalid(acc_res_tvalid),
    .acc_res_tlast(acc_res_tlast), .acc_res_tready(acc_res_tready),
    .m00_axis_tdata(m00_axis_tdata), .m00_axis_tvalid(m00_axis_tvalid),
    .m00_axis_tlast(m00_axis_tlast), .m00_axis_tready(m00_axis_tready),
    .m00_axis_tid(m00_axis_tid),
    .busy(busy), .len_err(len_err), .err(err), .job_count(job_count)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: pending requests, per-requester frames, scheduler history.
  bit            pend [2];
  logic [DW-1:0] data [2][SIZE];
  bit            bad  [2];
  int            idx  [2];
  bit            last_grant_m;
  int            job_count_m;
  bit            len_err_m;
  bit            err_m;

  function automatic int winner_m();
    if (pend[0] && pend[1]) return last_grant_m ? 0 : 1;
    return pend[1] ? 1 : 0;
  endfunction

  task automatic new_request(input int r);
    pend[r] = 1'b1;
    idx[r]  = 0;
    bad[r]  = ($urandom_range(0, 3) == 0);
    for (int i = 0; i < SIZE; i++) data[r][i] = $urandom;
  endtask

  task automatic drive_req(input int r, input bit v);
    logic [DW-1:0] d;
    bit tl;
    d  = data[r][(idx[r] < SIZE) ? idx[r] : 0];
    tl = (idx[r] == SIZE - 1) ^ (bad[r] && idx[r] == 0);
    if (r == 0) begin
      s00_axis_tdata = d; s00_axis_tvalid = v; s00_axis_tlast = tl;
    end else begin
      s01_axis_tdata = d; s01_axis_tvalid = v; s01_axis_tlast = tl;
    end
  endtask

  task automatic reset_model();
    pend[0] = 1'b0; pend[1] = 1'b0;
    last_grant_m = 1'b1; job_count_m = 0; len_err_m = 1'b0; err_m = 1'b0;
    s00_axis_tvalid = 1'b0; s01_axis_tvalid = 1'b0;
    acc_res_tvalid = 1'b0;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_rdy"}, {30'b0, s01_axis_tready, s00_axis_tready}, 0);
    check({tag, "_accv"}, 32'(acc_axis_tvalid), 0);
    check({tag, "_m00v"}, 32'(m00_axis_tvalid), 0);
    check({tag, "_jobs"}, 32'(job_count), 32'(job_count_m & 16'hFFFF));
    check({tag, "_lenerr"}, 32'(len_err), 32'(len_err_m));
    check({tag, "_err"}, 32'(err), 32'(err_m));
  endtask

  // Called right after a posedge with the DUT in IDLE. nres=0 means the
  // accelerator never answers.
  task automatic run_job(input int nres);
    int w, cyc, ri;
    bit fire, up_v, up_l;
    logic [DW-1:0] res [$];
    for (int r = 0; r < 2; r++) drive_req(r, pend[r]);
    w = winner_m();
    acc_axis_tready = ($urandom_range(0, 1) == 1);
    m00_axis_tready = ($urandom_range(0, 1) == 1);
    @(negedge clk);
    check_idle("idle");
    @(posedge clk); #1;
    cyc = 0;
    while (idx[w] < SIZE) begin
      @(negedge clk);
      up_v = (w == 1) ? s01_axis_tvalid : s00_axis_tvalid;
      up_l = (w == 1) ? s01_axis_tlast  : s00_axis_tlast;
      fire = up_v && acc_axis_tready;
      check("loser_rdy", 32'((w == 1) ? s00_axis_tready : s01_axis_tready), 0);
      check("load_rdy", 32'((w == 1) ? s01_axis_tready : s00_axis_tready), 32'(acc_axis_tready));
      check("acc_valid", 32'(acc_axis_tvalid), 32'(up_v));
      check("start_low", 32'(acc_start), 0);
      if (fire) begin
        check("acc_data", acc_axis_tdata, data[w][idx[w]]);
        check("acc_last", 32'(acc_axis_tlast), 32'(idx[w] == SIZE - 1));
        if (up_l != (idx[w] == SIZE - 1)) len_err_m = 1'b1;
      end
      @(posedge clk); #1;
      if (fire) idx[w]++;
      if (idx[w] < SIZE) begin
        drive_req(w, $urandom_range(0, 3) != 0);
        acc_axis_tready = ($urandom_range(0, 3) != 0);
      end
      cyc++;
      if (cyc > 200) begin
        check("load_timeout", 32'(cyc), 0);
        return;
      end
    end
    pend[w] = 1'b0;
    drive_req(w, 1'b0);
    for (int i = 0; i < nres; i++) res.push_back($urandom);
    acc_res_tvalid = (nres > 0);
    acc_res_tdata  = (nres > 0) ? res[0] : '0;
    acc_res_tlast  = (nres == 1);
    @(negedge clk);
    check("start_pulse", 32'(acc_start), 1);
    check("start_busy", 32'(busy), 1);
    check("early_res_rdy", 32'(acc_res_tready), 0);
    check("early_m00v", 32'(m00_axis_tvalid), 0);
    @(posedge clk); #1;
    if (nres == 0) begin
`ifdef FFT_SCHED_WDT_EN
      for (int k = 0; k < TMO; k++) begin
        @(negedge clk);
        check("wdt_busy", 32'(busy), 1);
        check("wdt_err", 32'(err), 0);
        @(posedge clk); #1;
      end
      last_grant_m = w[0];
      err_m = 1'b1;
`else
      for (int k = 0; k < 40; k++) begin
        @(negedge clk);
        check("hang_busy", 32'(busy), 1);
        check("hang_err", 32'(err), 0);
        @(posedge clk); #1;
      end
`endif
      return;
    end
    ri = 0; cyc = 0;
    while (ri < nres) begin
      @(negedge clk);
      fire = acc_res_tvalid && m00_axis_tready;
      check("tid", 32'(m00_axis_tid), 32'(w));
      check("start_once", 32'(acc_start), 0);
      check("res_rdy", 32'(acc_res_tready), 32'(m00_axis_tready));
      check("m00_valid", 32'(m00_axis_tvalid), 32'(acc_res_tvalid));
      if (acc_res_tvalid) check("m00_data", m00_axis_tdata, res[ri]);
      if (fire) check("m00_last", 32'(m00_axis_tlast), 32'(ri == nres - 1));
      @(posedge clk); #1;
      if (fire) ri++;
      if (ri < nres) begin
        acc_res_tdata   = res[ri];
        acc_res_tlast   = (ri == nres - 1);
        acc_res_tvalid  = ($urandom_range(0, 3) != 0);
        m00_axis_tready = ($urandom_range(0, 2) != 0);
      end else begin
        acc_res_tvalid = 1'b0;
      end
      cyc++;
      if (cyc > 200) begin
        check("drain_timeout", 32'(cyc), 0);
        return;
      end
    end
    last_grant_m = w[0];
    job_count_m++;
  endtask

  task automatic add_requests();
    for (int r = 0; r < 2; r++)
      if (!pend[r] && $urandom_range(0, 1) == 1) new_request(r);
    if (!pend[0] && !pend[1]) new_request(int'($urandom_range(0, 1)));
  endtask

  task automatic reset_mid_job();
    int w;
    if (!pend[0] && !pend[1]) new_request(0);
    for (int r = 0; r < 2; r++) drive_req(r, pend[r]);
    w = winner_m();
    acc_axis_tready = 1'b1;
    @(negedge clk);
    check("rm_idle_busy", 32'(busy), 0);
    @(posedge clk); #1;
    @(negedge clk);
    check("rm_load_rdy", 32'((w == 1) ? s01_axis_tready : s00_axis_tready), 1);
    @(posedge clk); #1;
    aresetn = 1'b0;
    @(posedge clk); #1;
    reset_model();
    s00_axis_tvalid = 1'b1;
    s01_axis_tvalid = 1'b1;
    @(negedge clk);
    check("rm_busy", 32'(busy), 0);
    check("rm_rdy", {30'b0, s01_axis_tready, s00_axis_tready}, 0);
    check("rm_accv", 32'(acc_axis_tvalid), 0);
    check("rm_start", 32'(acc_start), 0);
    check("rm_jobs", 32'(job_count), 0);
    check("rm_lenerr", 32'(len_err), 0);
    @(posedge clk); #1;
    s00_axis_tvalid = 1'b0;
    s01_axis_tvalid = 1'b0;
    aresetn = 1'b1;
  endtask

  initial begin
    aresetn = 1'b0;
    s00_axis_tdata = '0; s01_axis_tdata = '0; acc_res_tdata = '0;
    s00_axis_tlast = 1'b0; s01_axis_tlast = 1'b0; acc_res_tlast = 1'b0;
    acc_axis_tready = 1'b0; m00_axis_tready = 1'b0;
    reset_model();
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    check_idle("reset");
    check("reset_start", 32'(acc_start), 0);
    check("reset_res_rdy", 32'(acc_res_tready), 0);
    check("reset_tid", 32'(m00_axis_tid), 0);
    @(posedge clk); #1;
    aresetn = 1'b1;

    // both requesters valid straight after reset; r0 carries a known frame
    new_request(0);
    new_request(1);
    bad[0] = 1'b0;
    data[0][0] = 32'h40490FDB;
    data[0][SIZE-1] = 32'hC0490FDB;
    run_job(1);
    for (int j = 0; j < 30; j++) begin
      add_requests();
      run_job(int'($urandom_range(1, 3)));
    end

    reset_mid_job();
    for (int j = 0; j < 10; j++) begin
      add_requests();
      run_job(int'($urandom_range(1, 3)));
    end

    add_requests();
    run_job(0);
`ifdef FFT_SCHED_WDT_EN
    for (int j = 0; j < 3; j++) begin
      add_requests();
      run_job(int'($urandom_range(1, 3)));
    end
`else
    aresetn = 1'b0;
    reset_model();
    @(posedge clk); #1;
    aresetn = 1'b1;
    add_requests();
    run_job(2);
`endif

    s00_axis_tvalid = 1'b0;
    s01_axis_tvalid = 1'b0;
    @(negedge clk);
    check_idle("final");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
